// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_rd_pkg : shared types, defaults and width helper for fifo_rd_packer
// Revision    : 1.0
// ----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_idle_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_rd_idle_timer : saturating idle counter, expire high at TIMEOUT-1
// Revision           : 1.0
// ----------------------------------------------------------------------------
module fifo_rd_idle_timer
  import fifo_rd_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW    = clogb2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_rd_packer : packs FIFO read entries into wide words on a valid/ready
//                  stream, flushing partial words after an idle timeout
// Revision       : 1.0
// ----------------------------------------------------------------------------
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                             rd_clk_i,
  input  logic                             rst_ni,
  input  logic                             fifo_empty_i,
  output logic                             fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0]            fifo_dout_i,
  input  logic                             fifo_valid_i,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_o,
  output logic [PACK_RATIO-1:0]            m_keep_o
);

  localparam int            FW        = clogb2(PACK_RATIO + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(PACK_RATIO);
  localparam logic [FW-1:0] FILL_LAST = FW'(PACK_RATIO - 1);

  state_e                                state_q, state_d;
  logic [FW-1:0]                         fill_q, fill_d, fill_cnt;
  logic                                  inflight_q;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d, lanes_wr;
  logic                                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH*PACK_RATIO-1:0]      m_data_q, m_data_d;
  logic [PACK_RATIO-1:0]                 m_keep_q, m_keep_d;

  logic out_free, capture, last_lane, load_full, to_hold, hold_xfer;
  logic idle_en, idle_clr, expire, flush, load, rd_en;

  assign out_free  = !m_valid_q || m_ready_i;
  assign capture   = fifo_valid_i && (state_q == ST_FILL);
  assign last_lane = capture && (fill_q == FILL_LAST);
  assign load_full = last_lane && out_free;
  assign to_hold   = last_lane && !out_free;
  assign hold_xfer = (state_q == ST_HOLD) && out_free;
  assign idle_en   = (state_q == ST_FILL) && (fill_q != '0) && !fifo_valid_i && !inflight_q;
  assign flush     = idle_en && expire && out_free;
  assign load      = load_full || hold_xfer || flush;
  assign idle_clr  = !idle_en || flush;

  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_i    (rd_clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (idle_clr),
    .en_i     (idle_en),
    .expire_o (expire)
  );

  always_ff @(posedge rd_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (to_hold)   state_d = ST_HOLD;
      ST_HOLD: if (hold_xfer) state_d = ST_FILL;
      default:                state_d = ST_FILL;
    endcase
  end

  always_comb begin
    lanes_wr = lanes_q;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (capture && (fill_q == FW'(i))) begin
        lanes_wr[i] = fifo_dout_i;
      end
    end
    fill_cnt  = capture ? (fill_q + FW'(1)) : fill_q;
    fill_d    = load ? '0 : fill_cnt;
    // Emptied lanes return to zero so a flushed word carries zeros above fill.
    lanes_d   = load ? '0 : lanes_wr;
    m_valid_d = load || (m_valid_q && !m_ready_i);
    m_data_d  = load ? lanes_wr : m_data_q;
    m_keep_d  = m_keep_q;
    if (load) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        m_keep_d[i] = (FW'(i) < fill_cnt);
      end
    end
    // fill_d already counts this cycle's capture, so a pop issued now has a lane.
    rd_en = !fifo_empty_i && (state_d == ST_FILL) && (fill_d < FILL_MAX);
  end

  always_ff @(posedge rd_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q     <= '0;
      inflight_q <= 1'b0;
      lanes_q    <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
    end else begin
      fill_q     <= fill_d;
      inflight_q <= rd_en;
      lanes_q    <= lanes_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_keep_o     = m_keep_q;

endmodule
`default_nettype wire
